// File: rtl/poly_bisect_seq.sv
// poly_bisect_seq: multi-cycle bisection root finder for an integer-coefficient
// polynomial in signed fixed point Q(W-FRAC-1).FRAC. p(x) is evaluated by a
// Horner MAC that consumes one coefficient per cycle (DEG+1 cycles per point).
// Optional feature macro: BISECT_TOL_EXIT_EN adds a tol input that ends the
// search early when |p(m)| <= tol.
module poly_bisect_seq #(
    parameter int W        = 20,
    parameter int FRAC     = 15,
    parameter int CW       = 3,
    parameter int DEG      = 12,
    parameter int MAX_ITER = 24,
    parameter int IW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coef_wr,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          start,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
`ifdef BISECT_TOL_EXIT_EN
    input  logic [W-1:0]  tol,
`endif
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          exact,
    output logic [W-1:0]  root,
    output logic [W-1:0]  f_root,
    output logic [IW-1:0] iter_cnt
);

    localparam int ECW = $clog2(DEG + 1);

    typedef enum logic [2:0] {
        IDLE, EVAL_A, EVAL_B, CHECK, EVAL_M, UPDATE, FIN
    } state_t;

    state_t state, state_nxt;

    logic signed [CW-1:0]  c [0:DEG];
    logic signed [W-1:0]   a_r, b_r, fa, fb, fm, acc;
    logic        [ECW-1:0] ecnt, cidx;
    logic        [IW-1:0]  it;

    // Coefficient sign-extended to W bits and moved to the integer position.
    function automatic logic [W-1:0] coef_fx(input logic [CW-1:0] cv);
        logic [W-1:0] ext;
        ext = {{(W-CW){cv[CW-1]}}, cv};
        return ext << FRAC;
    endfunction

    // Midpoint in W+1 bits; bits [W:1] are the floor of the half-sum and
    // always fit in W bits because m lies between a and b.
    logic [W:0]          mid_sum;
    logic signed [W-1:0] m;
    assign mid_sum = {a_r[W-1], a_r} + {b_r[W-1], b_r};
    assign m       = mid_sum[W:1];

    // Horner step: the product keeps full 2W precision before the floor shift.
    logic signed [W-1:0]   x_sel;
    logic signed [2*W-1:0] prod, prod_sh;
    logic        [W-1:0]   horner_nxt;
    logic                  eval_last;

    always_comb begin
        x_sel = m;
        if (state == EVAL_A) x_sel = a_r;
        else if (state == EVAL_B) x_sel = b_r;
    end

    assign cidx       = ECW'(DEG) - ecnt;
    assign prod       = acc * x_sel;
    assign prod_sh    = prod >>> FRAC;
    assign horner_nxt = (ecnt == '0) ? coef_fx(c[cidx])
                                     : prod_sh[W-1:0] + coef_fx(c[cidx]);
    assign eval_last  = (ecnt == ECW'(DEG));

    // Interval checks and bisection decisions.
    logic                chk_err, go_left, upd_stop, tol_hit;
    logic        [IW-1:0] it_nxt;
    logic signed [W-1:0]  new_a, new_b;
    logic signed [W:0]    width_nxt;

    assign chk_err   = (a_r >= b_r) ||
                       (fa != '0 && fb != '0 && fa[W-1] == fb[W-1]);
    assign it_nxt    = it + 1'b1;
    assign go_left   = (fa[W-1] != fm[W-1]);
    assign new_a     = go_left ? a_r : m;
    assign new_b     = go_left ? m : b_r;
    assign width_nxt = {new_b[W-1], new_b} - {new_a[W-1], new_a};

`ifdef BISECT_TOL_EXIT_EN
    logic [W-1:0] fm_abs;
    always_comb begin
        fm_abs = fm;
        if (fm[W-1]) fm_abs = (fm == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} : -fm;
    end
    assign tol_hit = (fm_abs <= tol);
`else
    assign tol_hit = 1'b0;
`endif

    assign upd_stop = (fm == '0) || tol_hit || (it_nxt == IW'(MAX_ITER)) ||
                      (width_nxt <= 1);

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EVAL_A;
            EVAL_A:  if (eval_last) state_nxt = EVAL_B;
            EVAL_B:  if (eval_last) state_nxt = CHECK;
            CHECK:   state_nxt = (chk_err || fa == '0 || fb == '0) ? FIN : EVAL_M;
            EVAL_M:  if (eval_last) state_nxt = UPDATE;
            UPDATE:  state_nxt = upd_stop ? FIN : EVAL_M;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: coefficient store, Horner accumulator, interval and results.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DEG; i++) c[i] <= '0;
            a_r <= '0; b_r <= '0; fa <= '0; fb <= '0; fm <= '0; acc <= '0;
            ecnt <= '0; it <= '0;
            done <= 1'b0; err <= 1'b0; exact <= 1'b0;
            root <= '0; f_root <= '0; iter_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && coef_wr && coef_addr <= 4'(DEG))
                c[coef_addr] <= coef_data;
            case (state)
                IDLE: if (start) begin
                    a_r <= a_in; b_r <= b_in; it <= '0; ecnt <= '0;
                    err <= 1'b0; exact <= 1'b0;
                    root <= '0; f_root <= '0; iter_cnt <= '0;
                end
                EVAL_A, EVAL_B, EVAL_M: begin
                    acc  <= horner_nxt;
                    ecnt <= eval_last ? '0 : ecnt + 1'b1;
                    if (eval_last) begin
                        if (state == EVAL_A)      fa <= horner_nxt;
                        else if (state == EVAL_B) fb <= horner_nxt;
                        else                      fm <= horner_nxt;
                    end
                end
                CHECK: begin
                    iter_cnt <= it;
                    if (chk_err) begin
                        err <= 1'b1; root <= a_r; f_root <= fa;
                    end else if (fa == '0) begin
                        exact <= 1'b1; root <= a_r; f_root <= fa;
                    end else if (fb == '0) begin
                        exact <= 1'b1; root <= b_r; f_root <= fb;
                    end
                end
                UPDATE: begin
                    it <= it_nxt;
                    if (fm == '0) begin
                        exact <= 1'b1; root <= m; f_root <= fm; iter_cnt <= it_nxt;
                    end else begin
                        a_r <= new_a;
                        b_r <= new_b;
                        if (!go_left) fa <= fm;
                        if (upd_stop) begin
                            root <= m; f_root <= fm; iter_cnt <= it_nxt;
                        end
                    end
                end
                FIN: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_bisect_seq.sv
// Directed bench for poly_bisect_seq (default W=20 FRAC=15 DEG=12).
// Define BISECT_TOL_EXIT_EN for both files to exercise the tolerance exit.
module tb_poly_bisect_seq;

    localparam int W = 20;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          coef_wr;
    logic [3:0]    coef_addr;
    logic [2:0]    coef_data;
    logic          start;
    logic [W-1:0]  a_in, b_in;
`ifdef BISECT_TOL_EXIT_EN
    logic [W-1:0]  tol;
`endif
    logic          busy, done, err, exact;
    logic [W-1:0]  root, f_root;
    logic [IW-1:0] iter_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    poly_bisect_seq dut (
        .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_data(coef_data), .start(start), .a_in(a_in), .b_in(b_in),
`ifdef BISECT_TOL_EXIT_EN
        .tol(tol),
`endif
        .busy(busy), .done(done), .err(err), .exact(exact),
        .root(root), .f_root(f_root), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr_coef(input int addr, input logic [2:0] data);
        coef_wr = 1'b1; coef_addr = 4'(addr); coef_data = data;
        tick();
        coef_wr = 1'b0;
    endtask

    // Clears all coefficients, then sets c2, c1, c0.
    task automatic set_poly(input logic [2:0] c2, input logic [2:0] c1, input logic [2:0] c0);
        for (int i = 0; i <= 12; i++) wr_coef(i, 3'd0);
        wr_coef(2, c2); wr_coef(1, c1); wr_coef(0, c0);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string tag);
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [W-1:0] absf;

    initial begin
        reset = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        start = 1'b0; a_in = '0; b_in = '0;
`ifdef BISECT_TOL_EXIT_EN
        tol = '0;
`endif
        tick(); tick();
        reset = 1'b0;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_root", 32'(root), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_iter", 32'(iter_cnt), 32'd0);

        // p = x - 1 on [0, 2.0]: first midpoint is the exact root
        set_poly(3'd0, 3'd1, 3'b111);
        launch(20'd0, 20'd65536);
        chk("xm1_busy", 32'(busy), 32'd1);
        wait_done("xm1");
        chk("xm1_lat",   32'(cyc), 32'd43);
        chk("xm1_err",   32'(err), 32'd0);
        chk("xm1_exact", 32'(exact), 32'd1);
        chk("xm1_root",  32'(root), 32'd32768);
        chk("xm1_froot", 32'(f_root), 32'd0);
        chk("xm1_iter",  32'(iter_cnt), 32'd1);
        chk("xm1_busy_done", 32'(busy), 32'd0);
        tick();
        chk("xm1_done_pulse", 32'(done), 32'd0);

        // p = x - 1, a == b: bad interval
        launch(20'd32768, 20'd32768);
        wait_done("aeqb");
        chk("aeqb_lat",   32'(cyc), 32'd29);
        chk("aeqb_err",   32'(err), 32'd1);
        chk("aeqb_exact", 32'(exact), 32'd0);
        chk("aeqb_root",  32'(root), 32'd32768);

        // p = x - 1, root at a
        launch(20'd32768, 20'd65536);
        wait_done("fa0");
        chk("fa0_lat",   32'(cyc), 32'd29);
        chk("fa0_exact", 32'(exact), 32'd1);
        chk("fa0_root",  32'(root), 32'd32768);
        chk("fa0_iter",  32'(iter_cnt), 32'd0);

        // p = x^2 + 1 on [0, 1.0]: no sign change
        set_poly(3'd1, 3'd0, 3'd1);
        launch(20'd0, 20'd32768);
        wait_done("x2p1");
        chk("x2p1_lat",   32'(cyc), 32'd29);
        chk("x2p1_err",   32'(err), 32'd1);
        chk("x2p1_exact", 32'(exact), 32'd0);
        chk("x2p1_root",  32'(root), 32'd0);
        chk("x2p1_froot", 32'(f_root), 32'd32768);
        chk("x2p1_iter",  32'(iter_cnt), 32'd0);

        // p = x^2 - 2 on [1.0, 2.0]
        set_poly(3'd1, 3'd0, 3'b110);
        launch(20'd32768, 20'd65536);
        wait_done("sqrt2");
        chk("sqrt2_err",   32'(err), 32'd0);
        chk("sqrt2_range", 32'(root >= 20'd46339 && root <= 20'd46342), 32'd1);
        chk("sqrt2_busy",  32'(busy), 32'd0);

        // Reset while in EVAL_M aborts and clears the coefficient store
        launch(20'd32768, 20'd65536);
        repeat (32) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_root", 32'(root), 32'd0);
        begin
            int stale = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) stale++;
                tick();
            end
            chk("abort_no_done", 32'(stale), 32'd0);
        end
        launch(20'd0, 20'd65536);
        wait_done("cleared");
        chk("cleared_exact", 32'(exact), 32'd1);
        chk("cleared_root",  32'(root), 32'd0);
        set_poly(3'd1, 3'd0, 3'b110);
        launch(20'd32768, 20'd65536);
        wait_done("rerun");
        chk("rerun_err",   32'(err), 32'd0);
        chk("rerun_range", 32'(root >= 20'd46339 && root <= 20'd46342), 32'd1);

        // start and coef_wr while busy are ignored
        set_poly(3'd0, 3'd1, 3'b111);
        launch(20'd0, 20'd65536);
        repeat (5) begin tick(); cyc++; end
        coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 3'd2;
        start = 1'b1; a_in = 20'd100; b_in = 20'd200;
        tick(); cyc++;
        coef_wr = 1'b0; start = 1'b0;
        wait_done("busyign");
        chk("busyign_lat",  32'(cyc), 32'd43);
        chk("busyign_root", 32'(root), 32'd32768);
        chk("busyign_iter", 32'(iter_cnt), 32'd1);
        launch(20'd32768, 20'd65536);
        wait_done("busyign2");
        chk("busyign_coef", 32'(exact), 32'd1);
        chk("busyign_coef_err", 32'(err), 32'd0);

        // write and start in the same idle cycle: p = x becomes x - 1
        set_poly(3'd0, 3'd1, 3'd0);
        coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 3'b111;
        launch(20'd0, 20'd65536);
        coef_wr = 1'b0;
        wait_done("samecyc");
        chk("samecyc_root", 32'(root), 32'd32768);
        chk("samecyc_iter", 32'(iter_cnt), 32'd1);

`ifdef BISECT_TOL_EXIT_EN
        set_poly(3'd1, 3'd0, 3'b110);
        tol = 20'd327;
        launch(20'd32768, 20'd65536);
        wait_done("tol");
        absf = f_root[W-1] ? -f_root : f_root;
        chk("tol_err",   32'(err), 32'd0);
        chk("tol_bound", 32'(absf <= 20'd327), 32'd1);
        chk("tol_iter",  32'(iter_cnt < 5'd24), 32'd1);
`else
        absf = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
